// File: rtl/text_scroller_if.sv
// rtl/text_scroller_if.sv - video timing, scroll control and glyph ROM bundle for text_scroller
interface text_scroller_if;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       frame_tick;
  logic       scroll_en;
  logic [1:0] speed;
  logic [7:0] char_code;
  logic [2:0] glyph_row;
  logic [2:0] glyph_col;
  logic       rom_pixel;
  logic       pixel_out;

  // The scroller consumes timing/control and the ROM pixel, and produces ROM address and pixel.
  modport slave (
    input  hpos, vpos, display_on, frame_tick, scroll_en, speed, rom_pixel,
    output char_code, glyph_row, glyph_col, pixel_out
  );

  // The video/ROM side drives timing/control and the ROM pixel.
  modport master (
    output hpos, vpos, display_on, frame_tick, scroll_en, speed, rom_pixel,
    input  char_code, glyph_row, glyph_col, pixel_out
  );
endinterface

// File: rtl/text_scroller.sv
// rtl/text_scroller.sv - horizontally scrolling single-line text band with 2-stage pixel pipeline
module text_scroller #(
  parameter int SCALE_LOG2 = 2,
  parameter int TEXT_Y     = 200
) (
  input logic           clk,
  input logic           rst_n,
  text_scroller_if.slave bus
);

  localparam int BAND_H     = 8 << SCALE_LOG2;
  localparam int MSG_PERIOD = 90;

  // Message text, one ASCII byte per cell; indices outside 0..14 cannot occur.
  function automatic logic [7:0] msg_char(input logic [3:0] idx);
    logic [7:0] c;
    case (idx)
      4'd0:    c = 8'h44;
      4'd1:    c = 8'h72;
      4'd2:    c = 8'h69;
      4'd3:    c = 8'h76;
      4'd4:    c = 8'h69;
      4'd5:    c = 8'h6E;
      4'd6:    c = 8'h67;
      4'd7:    c = 8'h20;
      4'd8:    c = 8'h49;
      4'd9:    c = 8'h54;
      4'd10:   c = 8'h20;
      4'd11:   c = 8'h32;
      4'd12:   c = 8'h30;
      4'd13:   c = 8'h32;
      4'd14:   c = 8'h35;
      default: c = 8'h20;
    endcase
    return c;
  endfunction

  logic [6:0] scroll_off_q, scroll_off_d;
  logic [1:0] fcnt_q, fcnt_d;

  // Scroll state next-value: step when the frame counter has reached (or passed) the speed setting.
  always_comb begin
    scroll_off_d = scroll_off_q;
    fcnt_d       = fcnt_q;
    if (bus.frame_tick && bus.scroll_en) begin
      if (fcnt_q >= bus.speed) begin
        fcnt_d       = 2'd0;
        scroll_off_d = (scroll_off_q == 7'(MSG_PERIOD - 1)) ? 7'd0 : scroll_off_q + 7'd1;
      end else begin
        fcnt_d = fcnt_q + 2'd1;
      end
    end
  end

  // Scroll state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_off_q <= 7'd0;
      fcnt_q       <= 2'd0;
    end else begin
      scroll_off_q <= scroll_off_d;
      fcnt_q       <= fcnt_d;
    end
  end

  // Position decode. Widened to 11 bits so the column sum and band bounds never truncate.
  logic [10:0] vpos_ext;
  logic [10:0] v_rel;
  logic [10:0] col_sum;
  logic        in_band;
  logic [2:0]  fy;
  logic [6:0]  fx;
  logic [3:0]  char_idx;
  logic [2:0]  cell_col;
  logic        blank;

  assign vpos_ext = {1'b0, bus.vpos};
  assign in_band  = (vpos_ext >= 11'(TEXT_Y)) && (vpos_ext < 11'(TEXT_Y + BAND_H));
  assign v_rel    = vpos_ext - 11'(TEXT_Y);
  assign fy       = 3'(v_rel >> SCALE_LOG2);
  assign col_sum  = 11'(bus.hpos >> SCALE_LOG2) + {4'd0, scroll_off_q};
  assign fx       = 7'(col_sum % 11'(MSG_PERIOD));
  assign char_idx = 4'(fx / 7'd6);
  assign cell_col = 3'(fx % 7'd6);
  assign blank    = !in_band || (fy == 3'd7) || (cell_col == 3'd5);

  logic [7:0] char_code_q;
  logic [2:0] glyph_row_q;
  logic [2:0] glyph_col_q;
  logic       blank_q;
  logic       disp_q;
  logic       pixel_q;

  // Stage 1: register the ROM address plus the blank/visible flags that travel with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_code_q <= 8'h20;
      glyph_row_q <= 3'd0;
      glyph_col_q <= 3'd0;
      blank_q     <= 1'b0;
      disp_q      <= 1'b0;
    end else begin
      char_code_q <= blank ? 8'h20 : msg_char(char_idx);
      glyph_row_q <= blank ? 3'd0 : fy;
      glyph_col_q <= blank ? 3'd0 : cell_col;
      blank_q     <= blank;
      disp_q      <= bus.display_on;
    end
  end

  // Stage 2: gate the combinational ROM pixel with the delayed flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_q <= 1'b0;
    end else begin
      pixel_q <= bus.rom_pixel && !blank_q && disp_q;
    end
  end

  assign bus.char_code = char_code_q;
  assign bus.glyph_row = glyph_row_q;
  assign bus.glyph_col = glyph_col_q;
  assign bus.pixel_out = pixel_q;

endmodule

// File: tb/tb_text_scroller.sv
// tb/tb_text_scroller.sv - scoreboard bench for text_scroller with a behavioural reference model
module tb_text_scroller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  text_scroller_if bus();
  text_scroller #(.SCALE_LOG2(2), .TEXT_Y(200)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic force_rom = 1'b0;
  assign bus.rom_pixel = force_rom | ~(^{bus.char_code, bus.glyph_row, bus.glyph_col});

  typedef struct {
    logic [7:0] code;
    logic [2:0] row;
    logic [2:0] col;
    logic       pix;
  } exp_t;

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  int    m_off  = 0;
  int    m_fcnt = 0;
  string msg    = "Driving IT 2025";

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Apply one pixel of stimulus, predict its outputs from the text layout rules, advance the scroll model.
  task automatic drive(input int h, input int v, input bit don, input bit ft, input bit se, input int sp);
    exp_t e;
    int   fx, fy, ci, cc;
    bit   in_band, blank, rom;
    @(negedge clk);
    bus.hpos       = 10'(h);
    bus.vpos       = 10'(v);
    bus.display_on = don;
    bus.frame_tick = ft;
    bus.scroll_en  = se;
    bus.speed      = 2'(sp);
    in_band = (v >= 200) && (v < 232);
    fy      = in_band ? (v - 200) / 4 : 0;
    fx      = ((h / 4) + m_off) % 90;
    ci      = fx / 6;
    cc      = fx % 6;
    blank   = !in_band || fy == 7 || cc == 5;
    e.code  = blank ? 8'h20 : msg[ci];
    e.row   = blank ? 3'd0 : 3'(fy);
    e.col   = blank ? 3'd0 : 3'(cc);
    rom     = force_rom | ~(^{e.code, e.row, e.col});
    e.pix   = rom && !blank && don;
    q.push_back(e);
    if (ft && se) begin
      if (m_fcnt >= sp) begin
        m_fcnt = 0;
        m_off  = (m_off + 1) % 90;
      end else begin
        m_fcnt = m_fcnt + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Monitor: stage-1 outputs one cycle after stimulus, pixel one cycle later still.
  exp_t pend;
  bit   pend_v = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pend_v = 1'b0;
    end else begin
      if (pend_v) check("pixel_out", int'(bus.pixel_out), int'(pend.pix));
      pend_v = 1'b0;
      if (q.size() > 0) begin
        pend = q.pop_front();
        check("char_code", int'(bus.char_code), int'(pend.code));
        check("glyph_row", int'(bus.glyph_row), int'(pend.row));
        check("glyph_col", int'(bus.glyph_col), int'(pend.col));
        pend_v = 1'b1;
      end
    end
  end

  initial begin
    bus.hpos       = 10'd0;
    bus.vpos       = 10'd208;
    bus.display_on = 1'b1;
    bus.frame_tick = 1'b0;
    bus.scroll_en  = 1'b0;
    bus.speed      = 2'd0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_char_code", int'(bus.char_code), 8'h20);
    check("rst_glyph_row", int'(bus.glyph_row), 0);
    check("rst_glyph_col", int'(bus.glyph_col), 0);
    check("rst_pixel_out", int'(bus.pixel_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First cell of the message, visible and hidden.
    drive(0, 200, 1, 0, 0, 0);
    drive(0, 200, 0, 0, 0, 0);
    idle(3);

    // Blank cases with the ROM forced lit.
    force_rom = 1'b1;
    drive(20, 200, 1, 0, 0, 0);
    drive(0, 228, 1, 0, 0, 0);
    drive(0, 199, 1, 0, 0, 0);
    drive(0, 232, 1, 0, 0, 0);
    drive(4, 204, 1, 0, 0, 0);
    idle(3);
    force_rom = 1'b0;

    // Right edge of the screen wraps into the message.
    drive(1020, 200, 1, 0, 0, 0);

    // Full scroll cycle at the fastest speed.
    drive(0, 200, 1, 1, 1, 0);
    drive(0, 200, 1, 0, 1, 0);
    for (int i = 0; i < 89; i++) drive(0, 200, 1, 1, 1, 0);
    drive(0, 200, 1, 0, 1, 0);

    // Slowest speed, then held ticks.
    for (int i = 0; i < 9; i++) drive(i * 24, 200 + i, 1, 1, 1, 3);
    for (int i = 0; i < 10; i++) drive(i * 24, 200 + i, 1, 1, 0, 3);
    for (int i = 0; i < 4; i++) drive(i * 24, 210, 1, 0, 1, 3);

    // Lowering speed below the frame counter forces an immediate step.
    drive(0, 200, 1, 1, 1, 3);
    drive(0, 200, 1, 1, 1, 3);
    drive(0, 200, 1, 1, 1, 0);
    drive(0, 200, 1, 0, 1, 0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(1023), $urandom_range(240, 190), 1'($urandom_range(3) != 0),
            1'($urandom_range(7) == 0), 1'($urandom_range(3) != 0), $urandom_range(3));
    end
    idle(3);

    // Reset mid-band with a non-zero scroll offset.
    @(negedge clk);
    rst_n = 1'b0;
    m_off = 0;
    m_fcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 37; i++) drive(0, 200, 1, 1, 1, 0);
    drive(0, 208, 1, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_off = 0;
    m_fcnt = 0;
    #1;
    check("midrst_char_code", int'(bus.char_code), 8'h20);
    check("midrst_glyph_row", int'(bus.glyph_row), 0);
    check("midrst_glyph_col", int'(bus.glyph_col), 0);
    check("midrst_pixel_out", int'(bus.pixel_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 200, 1, 0, 0, 0);
    drive(8, 204, 1, 0, 0, 0);
    idle(4);

    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/text_scroller.md
TEXT_SCROLLER -- requirements
Module: text_scroller

Interface
REQ-001 SHALL have parameter SCALE_LOG2, default 2: log2 of screen pixels per font pixel, both axes.
REQ-002 SHALL have parameter TEXT_Y, default 200: first screen line of the text band.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port hpos, input, 10: current screen column from video timing.
REQ-006 SHALL have port vpos, input, 10: current screen line from video timing.
REQ-007 SHALL have port display_on, input, 1: visible-area flag aligned with hpos/vpos.
REQ-008 SHALL have port frame_tick, input, 1: one-cycle pulse, once per frame.
REQ-009 SHALL have port scroll_en, input, 1: 1 = scrolling advances, 0 = hold.
REQ-010 SHALL have port speed, input, 2: scroll step every speed+1 frame_ticks.
REQ-011 SHALL have port char_code, output, 8: ASCII code to the glyph ROM.
REQ-012 SHALL have port glyph_row, output, 3: glyph row (0 = top) to the glyph ROM.
REQ-013 SHALL have port glyph_col, output, 3: glyph column (0 = leftmost) to the glyph ROM.
REQ-014 SHALL have port rom_pixel, input, 1: combinational ROM pixel for the current char_code/glyph_row/glyph_col.
REQ-015 SHALL have port pixel_out, output, 1: text pixel, 1 = lit.

Function
REQ-016 SHALL hold a fixed 15-entry message, index 0..14: 44 72 69 76 69 6E 67 20 49 54 20 32 30 32 35 (hex, "Driving IT 2025").
REQ-017 Layout SHALL use 6x8 font-pixel cells: columns 0-4 glyph, column 5 gap; rows 0-6 glyph, row 7 gap. Message period is 90 font-pixels and repeats horizontally.
REQ-018 SHALL hold a 7-bit scroll_off, range 0..89, and a 2-bit frame counter fcnt.
REQ-019 On frame_tick=1 with scroll_en=1: if fcnt==speed, fcnt<=0 and scroll_off<=scroll_off+1, wrapping 89->0; else fcnt<=fcnt+1.
REQ-020 With frame_tick=0 or scroll_en=0, fcnt and scroll_off SHALL hold.
REQ-021 If speed is lowered below the current fcnt, the next enabled tick SHALL step scroll_off and clear fcnt.
REQ-022 Band test: in_band = (vpos >= TEXT_Y) and (vpos < TEXT_Y + 8*2^SCALE_LOG2); fy = (vpos - TEXT_Y) >> SCALE_LOG2.
REQ-023 Column: fx = ((hpos >> SCALE_LOG2) + scroll_off) mod 90, computed exactly with no truncation; char_idx = fx / 6; cell_col = fx mod 6.
REQ-024 blank = !in_band or fy==7 or cell_col==5.
REQ-025 Stage 1, registered one cycle after hpos/vpos: char_code = 0x20 if blank, else message[char_idx]; glyph_row = fy[2:0], or 0 if blank; glyph_col = cell_col, or 0 if blank. blank and display_on SHALL be delayed alongside.
REQ-026 Stage 2: pixel_out <= rom_pixel and !blank_d and display_on_d. Total latency from hpos/vpos to pixel_out SHALL be exactly 2 cycles.
REQ-027 Scroll state changes SHALL affect only fx computation in the cycle after the update; the pipeline SHALL never stall.

Reset
REQ-028 While rst_n=0, asynchronously: scroll_off=0, fcnt=0, char_code=0x20, glyph_row=0, glyph_col=0, pixel_out=0, delayed flags=0.
REQ-029 Reset mid-frame SHALL take effect immediately. After release, the first valid pixel_out SHALL appear 2 cycles after the first rising edge.

Verification
REQ-030 rst_n pulsed low mid-band with scroll_off=37 -> outputs immediately 0x20/0/0/0; after release, hpos=0 vpos=200 maps to char 0x44.
REQ-031 Defaults, scroll_off=0, hpos=0, vpos=200, display_on=1, ROM model -> next cycle char_code=0x44, row 0, col 0; pixel_out=1 on cycle 2. Same input with display_on=0 -> pixel_out=0.
REQ-032 hpos=20 (fx=5), vpos=228 (fy=7), vpos=199, or vpos=232 -> char_code=0x20 and pixel_out=0, with rom_pixel forced 1.
REQ-033 hpos=1020, scroll_off=0 -> fx=75: char_code=0x30, glyph_col=3.
REQ-034 speed=0, scroll_en=1, 90 frame_ticks -> scroll_off returns to 0. After 1 tick, hpos=0 gives glyph_col=1.
REQ-035 speed=3 -> scroll_off steps on every 4th tick; scroll_en=0 with 10 ticks -> scroll_off and fcnt unchanged.
